csr_timer: RTL and testbench
============================

// Module: csr_timer
// PURPOSE
//   Constant timer and stable counter for the CSR subsystem. Owns the TID, TCFG, TVAL and
//   TICLR registers. Counts TVAL down and latches the timer interrupt, which feeds
//   ESTAT.IS[11] in the CSR file.
//   Also provides the 64-bit free-running stable counter consumed by rdcntvl/rdcntvh in EX.
//   Sits beside the CSR file on the same csr_* write/read bus; the parent ORs csr_rvalue
//   with the CSR file's value.
// PARAMETERS
//   TIMER_W   32     timer width; TCFG.InitVal = [TIMER_W-1:2], TVAL = [TIMER_W-1:0]
//   TID_INIT  32'h0  reset value of TID
// PORTS
//   clk         in   1   core clock
//   resetn      in   1   asynchronous, active-low reset
//   csr_we      in   1   CSR write enable (from WB, same strobe as the CSR file)
//   csr_num     in   14  CSR address
//   csr_wmask   in   32  write bit mask
//   csr_wvalue  in   32  write data
//   csr_rvalue  out  32  read data for TID/TCFG/TVAL/TICLR; 0 for any other csr_num
//   csr_hit     out  1   csr_num is one of 0x40/0x41/0x42/0x44
//   timer_int   out  1   TI flag -> ESTAT.IS[11]
//   cnt_value   out  64  stable counter
// BEHAVIOUR
//   Address map
//     TID=0x40, TCFG=0x41, TVAL=0x42, TICLR=0x44.
//   Masked writes
//     Every write is new = wmask&wvalue | ~wmask&old.
//     csr_rvalue and csr_hit are combinational on csr_num.
//   Reset (async, resetn=0)
//     TID=TID_INIT; TCFG={InitVal,Periodic,En}=0; TVAL=all ones; armed=0; TI=0; cnt=0.
//     Outputs: timer_int=0, cnt_value=0.
//     Reset mid-count: all of the above are forced immediately; no pending interrupt survives.
//   TID
//     32-bit read/write, no side effects.
//   TCFG
//     Bit0 = En, bit1 = Periodic, [TIMER_W-1:2] = InitVal. Reads back as written.
//     Any write with resulting En=1: TVAL <= {InitVal,2'b00} and armed <= 1 at that edge.
//     Any write with resulting En=0: armed <= 0 and TVAL holds its value.
//   Counting (each edge, when no TCFG write occurs)
//     armed && TVAL!=0: TVAL <= TVAL-1.
//     armed && TVAL==0: TI <= 1 (mandatory, every time this condition holds).
//       Periodic=1: TVAL <= {InitVal,2'b00}; armed stays 1.
//       Periodic=0: TVAL <= all ones; armed <= 0 (one-shot expires). TCFG.En still reads 1.
//     !armed: TVAL holds.
//   Interval
//     Loading L gives TI=1 visible L+1 cycles after the loading edge. The period is L+1 cycles.
//     InitVal=0 with Periodic=1 fires every cycle.
//   TVAL
//     Read-only. Writes are ignored.
//   TICLR
//     Reads as 0. A write with (wmask[0]&wvalue[0])=1 clears TI at that edge.
//     Other TICLR bits are ignored.
//   Simultaneous events
//     TI set and TICLR clear on the same edge: set wins, TI=1, so a fresh expiry is never lost.
//     TCFG write and timer expiry on the same edge: the TCFG write wins (reload/disarm).
//       TI is not set that edge.
//     A TCFG write does not itself touch TI.
//   Stable counter
//     cnt_value <= cnt_value+1 every edge out of reset.
//     Wraps from 2^64-1 to 0. Not writable.
//   Latency
//     Register writes are visible on csr_rvalue the cycle after the write edge.
// TESTING
//   1. Release reset.
//      -> Read TVAL=32'hFFFFFFFF, TCFG=0, TID=TID_INIT, timer_int=0.
//      -> cnt_value = 0,1,2,... on consecutive cycles.
//   2. One-shot: write TCFG=32'h11 (InitVal=4, En=1) at edge k.
//      -> TVAL=16 at k+1, 0 at k+17.
//      -> timer_int rises at k+18 and stays high; TVAL=FFFFFFFF afterwards and no further reload.
//   3. Periodic: write TCFG=32'h0B (InitVal=2, En=1, Periodic=1).
//      -> TVAL cycles 8..0; TI set every 9 cycles.
//      -> TICLR write of 1 drops timer_int the next cycle until the next expiry.
//   4. Collision: issue a TICLR write on exactly the expiry edge of test 3.
//      -> timer_int remains 1.
//   5. Masked writes:
//      a. TCFG write wmask=32'h1, wvalue=0 while counting -> counting freezes at the current TVAL.
//      b. TVAL write -> no change.
//      c. TID write 32'hDEADBEEF with wmask=32'hFFFF0000 -> TID reads 32'hDEAD0000
//         (from TID_INIT=0).
//   6. Assert resetn low mid-count with TI=1.
//      -> timer_int=0, cnt_value=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/csr_timer.sv
// csr_timer: constant timer (TID/TCFG/TVAL/TICLR) and 64-bit stable counter.
// It shares the CSR write/read bus with the CSR file. Its read data is zero
// for addresses it does not own, so the parent can OR it with the CSR file's read data.
//
// Bus protocol: there is no valid/ready handshake on this bus. csr_we is a
// single-cycle write strobe. On every rising clk edge with csr_we=1, the
// register selected by csr_num takes (wmask & wvalue) | (~wmask & old).
// Reads are purely combinational on csr_num. Written values appear on
// csr_rvalue in the cycle after the write edge.
module csr_timer #(
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic [31:0] csr_rvalue,
  output logic        csr_hit,
  output logic        timer_int,
  output logic [63:0] cnt_value
);

  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  localparam logic [TIMER_W-1:0] TVAL_ONES = '1;
  localparam logic [TIMER_W-1:0] TVAL_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};

  // Architectural state
  logic [31:0]        tid;
  logic [TIMER_W-1:0] tcfg;   // {InitVal, Periodic, En}
  logic [TIMER_W-1:0] tval;
  logic               armed;  // countdown active; cleared when a one-shot expires
  logic               ti;
  logic [63:0]        cnt;

  // Address decode
  logic sel_tid;
  logic sel_tcfg;
  logic sel_tval;
  logic sel_ticlr;

  assign sel_tid   = (csr_num == CSR_TID);
  assign sel_tcfg  = (csr_num == CSR_TCFG);
  assign sel_tval  = (csr_num == CSR_TVAL);
  assign sel_ticlr = (csr_num == CSR_TICLR);

  // Write strobes. TVAL is read-only, so it has no write strobe.
  logic wr_tid;
  logic wr_tcfg;
  logic wr_ticlr;

  assign wr_tid   = csr_we & sel_tid;
  assign wr_tcfg  = csr_we & sel_tcfg;
  assign wr_ticlr = csr_we & sel_ticlr;

  // Masked-write results
  logic [31:0]        tid_next;
  logic [TIMER_W-1:0] tcfg_next;

  assign tid_next  = (csr_wmask & csr_wvalue) | (~csr_wmask & tid);
  assign tcfg_next = (csr_wmask[TIMER_W-1:0] & csr_wvalue[TIMER_W-1:0])
                   | (~csr_wmask[TIMER_W-1:0] & tcfg);

  // Field views
  logic               tcfg_periodic;
  logic               tcfg_next_en;
  logic [TIMER_W-1:0] reload_cur;   // reload value from the current InitVal
  logic [TIMER_W-1:0] reload_new;   // reload value from the InitVal being written

  assign tcfg_periodic = tcfg[1];
  assign tcfg_next_en  = tcfg_next[0];
  assign reload_cur    = {tcfg[TIMER_W-1:2], 2'b00};
  assign reload_new    = {tcfg_next[TIMER_W-1:2], 2'b00};

  // An expiry happens when an armed counter is sitting at zero. A TCFG write
  // on the same edge takes priority, so that edge is not counted as an expiry.
  logic tval_zero;
  logic expire;
  logic ti_clear;

  assign tval_zero = (tval == '0);
  assign expire    = armed & tval_zero & ~wr_tcfg;
  assign ti_clear  = wr_ticlr & csr_wmask[0] & csr_wvalue[0];

  // TID: plain masked read/write register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tid <= TID_INIT;
    end else if (wr_tid) begin
      tid <= tid_next;
    end
  end

  // TCFG: masked read/write configuration. It always reads back exactly as written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg <= '0;
    end else if (wr_tcfg) begin
      tcfg <= tcfg_next;
    end
  end

  // Countdown engine: a TCFG write reloads or disarms; otherwise count, reload or expire
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tval  <= TVAL_ONES;
      armed <= 1'b0;
    end else if (wr_tcfg) begin
      if (tcfg_next_en) begin
        tval  <= reload_new;
        armed <= 1'b1;
      end else begin
        armed <= 1'b0;
      end
    end else if (armed) begin
      if (!tval_zero) begin
        tval <= tval - TVAL_ONE;
      end else if (tcfg_periodic) begin
        tval <= reload_cur;
      end else begin
        // One-shot expiry: park TVAL at all ones and stop. TCFG.En keeps reading 1.
        tval  <= TVAL_ONES;
        armed <= 1'b0;
      end
    end
  end

  // Interrupt flag. A set on the same edge as a TICLR clear wins, so a fresh expiry is kept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ti <= 1'b0;
    end else if (expire) begin
      ti <= 1'b1;
    end else if (ti_clear) begin
      ti <= 1'b0;
    end
  end

  // Stable counter: free-running and wraps naturally at 2^64
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 64'd1;
    end
  end

  // Read mux: zero for TICLR and for addresses this block does not own
  always_comb begin
    csr_rvalue = '0;
    case (1'b1)
      sel_tid:  csr_rvalue = tid;
      sel_tcfg: csr_rvalue[TIMER_W-1:0] = tcfg;
      sel_tval: csr_rvalue[TIMER_W-1:0] = tval;
      default:  csr_rvalue = '0;
    endcase
  end

  assign csr_hit   = sel_tid | sel_tcfg | sel_tval | sel_ticlr;
  assign timer_int = ti;
  assign cnt_value = cnt;

endmodule

// File: tb/tb_csr_timer.sv
// tb_csr_timer: directed plus randomized checks of csr_timer against a reference model.
// The model computes TVAL from the load time and the period using arithmetic.
module tb_csr_timer;

  localparam logic [13:0] A_TID   = 14'h40;
  localparam logic [13:0] A_TCFG  = 14'h41;
  localparam logic [13:0] A_TVAL  = 14'h42;
  localparam logic [13:0] A_TICLR = 14'h44;

  // Clock / reset
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        csr_we = 1'b0;
  logic [13:0] csr_num = '0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_wvalue = '0;
  logic [31:0] csr_rvalue;
  logic        csr_hit;
  logic        timer_int;
  logic [63:0] cnt_value;

  always #5 clk = ~clk;

  csr_timer #(.TIMER_W(32), .TID_INIT(32'h0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .csr_we     (csr_we),
    .csr_num    (csr_num),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .csr_rvalue (csr_rvalue),
    .csr_hit    (csr_hit),
    .timer_int  (timer_int),
    .cnt_value  (cnt_value)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model. m_c is the index of the last edge applied. While the
  // timer runs, TVAL held value m_len just after edge m_w.
  logic [31:0] m_tid;
  logic [31:0] m_tcfg;
  logic [31:0] m_frozen;
  logic        m_run;
  logic        m_per;
  logic        m_ti;
  longint      m_len;
  longint      m_w;
  longint      m_c;
  logic [63:0] m_cnt;

  function automatic logic [31:0] tval_model();
    longint e;
    e = m_c - m_w;
    if (!m_run) return m_frozen;
    if (m_per) return 32'(m_len - (e % (m_len + 1)));
    return 32'(m_len - e);
  endfunction

  function automatic logic [31:0] exp_read(input logic [13:0] a);
    case (a)
      A_TID:   return m_tid;
      A_TCFG:  return m_tcfg;
      A_TVAL:  return tval_model();
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_hit(input logic [13:0] a);
    return (a == A_TID) || (a == A_TCFG) || (a == A_TVAL) || (a == A_TICLR);
  endfunction

  task automatic model_reset();
    m_tid    = 32'h0;
    m_tcfg   = 32'h0;
    m_frozen = 32'hFFFF_FFFF;
    m_run    = 1'b0;
    m_per    = 1'b0;
    m_ti     = 1'b0;
    m_len    = 0;
    m_w      = 0;
    m_cnt    = 64'h0;
  endtask

  // Apply one clock edge's worth of behaviour to the model
  task automatic model_edge(input logic we, input logic [13:0] num,
                            input logic [31:0] mask, input logic [31:0] val);
    logic [31:0] cur;
    logic [31:0] nc;
    logic        fire;
    cur  = tval_model();
    fire = m_run && (cur == 32'h0);
    m_c  = m_c + 1;
    m_cnt = m_cnt + 64'd1;
    if (we && num == A_TCFG) begin
      nc = (mask & val) | (~mask & m_tcfg);
      m_tcfg = nc;
      if (nc[0]) begin
        m_run = 1'b1;
        m_w   = m_c;
        m_len = longint'({nc[31:2], 2'b00});
        m_per = nc[1];
      end else begin
        m_run    = 1'b0;
        m_frozen = cur;
      end
    end else if (fire) begin
      m_ti = 1'b1;
      if (!m_per) begin
        m_run    = 1'b0;
        m_frozen = 32'hFFFF_FFFF;
      end
    end
    if (we && num == A_TICLR && mask[0] && val[0] && !fire) m_ti = 1'b0;
    if (we && num == A_TID) m_tid = (mask & val) | (~mask & m_tid);
  endtask

  // Scoreboard compare
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Driver: called at a negedge. It drives one bus cycle and returns at the next negedge.
  task automatic step(input logic we, input logic [13:0] num,
                      input logic [31:0] mask, input logic [31:0] val);
    csr_we = we; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    @(posedge clk);
    model_edge(we, num, mask, val);
    @(negedge clk);
    csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
  endtask

  task automatic idle();
    step(1'b0, A_TVAL, 32'h0, 32'h0);
  endtask

  // Check outputs plus one register read, mid-cycle
  task automatic check_cycle(input logic [13:0] rd);
    csr_we = 1'b0; csr_num = rd;
    #1;
    chk("timer_int", {63'h0, timer_int}, {63'h0, m_ti});
    chk("cnt_value", cnt_value, m_cnt);
    chk($sformatf("read_%0h", rd), {32'h0, csr_rvalue}, {32'h0, exp_read(rd)});
    chk($sformatf("hit_%0h", rd), {63'h0, csr_hit}, {63'h0, exp_hit(rd)});
  endtask

  logic [13:0] rd_list [7] = '{14'h40, 14'h41, 14'h42, 14'h44, 14'h43, 14'h0, 14'h45};

  initial begin
    logic [31:0] held;
    logic        found;
    m_c = 0;
    model_reset();

    // 1. Reset values and the stable counter start
    #1;
    chk("rst_timer_int", {63'h0, timer_int}, 64'h0);
    chk("rst_cnt", cnt_value, 64'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_cycle(A_TVAL);
    chk("rst_tval", {32'h0, csr_rvalue}, 64'hFFFF_FFFF);
    check_cycle(A_TCFG);
    check_cycle(A_TID);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_cycle(A_TVAL);
    end
    chk("cnt_after3", cnt_value, 64'd3);

    // 2. One-shot, InitVal=4 -> TVAL loads 16
    step(1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h11);
    check_cycle(A_TVAL);
    chk("oneshot_load", {32'h0, csr_rvalue}, 64'd16);
    for (int i = 0; i < 16; i++) begin
      idle();
      check_cycle(A_TVAL);
    end
    chk("oneshot_zero", {32'h0, csr_rvalue}, 64'd0);
    chk("oneshot_no_ti_yet", {63'h0, timer_int}, 64'h0);
    idle();
    check_cycle(A_TVAL);
    chk("oneshot_ti", {63'h0, timer_int}, 64'h1);
    chk("oneshot_parked", {32'h0, csr_rvalue}, 64'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      idle();
      check_cycle(A_TVAL);
    end
    check_cycle(A_TCFG);

    // 3. Periodic, InitVal=2 -> period 9
    step(1'b1, A_TICLR, 32'h1, 32'h1);
    check_cycle(A_TVAL);
    chk("ticlr_drop", {63'h0, timer_int}, 64'h0);
    step(1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h0B);
    check_cycle(A_TVAL);
    for (int i = 0; i < 30; i++) begin
      idle();
      check_cycle(A_TVAL);
    end
    step(1'b1, A_TICLR, 32'hFFFF_FFFF, 32'h1);
    check_cycle(A_TVAL);
    chk("periodic_clear", {63'h0, timer_int}, 64'h0);

    // 4. TICLR on the exact expiry edge: set wins
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_run && tval_model() == 32'h0) begin
        found = 1'b1;
        break;
      end
      idle();
      check_cycle(A_TVAL);
    end
    chk("expiry_found", {63'h0, found}, 64'h1);
    step(1'b1, A_TICLR, 32'h1, 32'h1);
    check_cycle(A_TVAL);
    chk("collision_ti", {63'h0, timer_int}, 64'h1);

    // 5a. Masked TCFG write clearing only En freezes TVAL
    repeat (3) idle();
    check_cycle(A_TVAL);
    held = csr_rvalue;
    step(1'b1, A_TCFG, 32'h1, 32'h0);
    check_cycle(A_TCFG);
    chk("tcfg_masked", {32'h0, csr_rvalue}, 64'h0A);
    for (int i = 0; i < 4; i++) begin
      idle();
      check_cycle(A_TVAL);
    end
    chk("frozen_tval", {32'h0, csr_rvalue}, {32'h0, held});

    // 5b. TVAL is read-only
    step(1'b1, A_TVAL, 32'hFFFF_FFFF, 32'h1234_5678);
    check_cycle(A_TVAL);
    chk("tval_ro", {32'h0, csr_rvalue}, {32'h0, held});

    // 5c. Masked TID write
    step(1'b1, A_TID, 32'hFFFF_0000, 32'hDEAD_BEEF);
    check_cycle(A_TID);
    chk("tid_masked", {32'h0, csr_rvalue}, 64'hDEAD_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] mask;
      logic [31:0] val;
      mask = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      val  = $urandom_range(0, 31);
      case ($urandom_range(0, 11))
        0, 1:    step(1'b1, A_TCFG, mask, val);
        2, 3:    step(1'b1, A_TICLR, mask, $urandom);
        4:       step(1'b1, A_TID, mask, $urandom);
        5:       step(1'b1, A_TVAL, mask, $urandom);
        6:       step(1'b1, 14'h43, mask, $urandom);
        default: idle();
      endcase
      check_cycle(rd_list[$urandom_range(0, 6)]);
    end

    // 6. Async reset mid-count with TI set (InitVal=0 periodic fires every cycle)
    step(1'b1, A_TCFG, 32'hFFFF_FFFF, 32'h3);
    idle();
    check_cycle(A_TVAL);
    chk("pre_reset_ti", {63'h0, timer_int}, 64'h1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("async_rst_ti", {63'h0, timer_int}, 64'h0);
    chk("async_rst_cnt", cnt_value, 64'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_cycle(A_TVAL);
    check_cycle(A_TCFG);
    for (int i = 0; i < 5; i++) begin
      idle();
      check_cycle(rd_list[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
